// File: rtl/ram_dump_uart_if.sv
// Handshake and RAM-port bundle for the RAM dump UART.
// The slave side is the dump engine; the master side is the host/RAM.
interface ram_dump_uart_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] ram_addr;
    logic       ram_rd_en;
    logic [7:0] ram_data;
    logic       tx;

    modport master (
        output start,
        output ram_data,
        input  busy,
        input  done,
        input  ram_addr,
        input  ram_rd_en,
        input  tx
    );

    modport slave (
        input  start,
        input  ram_data,
        output busy,
        output done,
        output ram_addr,
        output ram_rd_en,
        output tx
    );
endinterface

// File: rtl/ram_dump_uart.sv
// Dumps the 16-byte program RAM over an 8N1 UART, preceded by a sync byte.
// Outputs decode from registered state so reset forces the line idle at once.
module ram_dump_uart #(
    parameter int          CLKS_PER_BIT = 234,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    ram_dump_uart_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FETCH,
        LOAD
    } state_t;

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [4:0]    addr_q, addr_d;
    logic          hdr_q, hdr_d;
    logic          done_q, done_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
            hdr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            hdr_q   <= hdr_d;
            done_q  <= done_d;
        end
    end

    // Next-state: bit timing, byte sequencing and RAM fetch
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        hdr_d   = hdr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d = SYNC_BYTE;
                    addr_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                    hdr_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        if (hdr_q || addr_q < 5'd16) begin
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        // start bit consumes no data; data bits shift out LSB first
                        if (bit_q != 4'd0) begin
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = bus.ram_data;
                addr_d  = addr_q + 5'd1;
                hdr_d   = 1'b0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = SEND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
        bus.ram_rd_en = (state_q == FETCH);
        bus.ram_addr  = 4'd0;
        bus.tx        = 1'b1;
        if (state_q == FETCH || state_q == LOAD) begin
            bus.ram_addr = addr_q[3:0];
        end
        if (state_q == SEND) begin
            if (bit_q == 4'd0) begin
                bus.tx = 1'b0;
            end else if (bit_q == 4'd9) begin
                bus.tx = 1'b1;
            end else begin
                bus.tx = shreg_q[0];
            end
        end
    end

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: records whole dumps and compares them to a
// waveform and byte list derived from the UART framing rules.
module tb_ram_dump_uart;

    localparam int CPB      = 4;
    localparam int NB       = 17;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int SLOT     = BYTE_CYC + 2;
    localparam int DONE_IDX = NB * BYTE_CYC + (NB - 1) * 2;
    localparam int NCAP     = DONE_IDX + 8;

    logic clk;
    logic rst;
    ram_dump_uart_if bus ();

    ram_dump_uart #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] ram [16];

    bit         tr_tx   [NCAP];
    bit         tr_busy [NCAP];
    bit         tr_done [NCAP];
    bit         tr_rd   [NCAP];
    logic [3:0] tr_addr [NCAP];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with one cycle of read latency
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_data <= ram[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    endtask

    task automatic start_dump();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // mode 0: start low, 1: stray pulses at 50/300, 2: start held high
    task automatic capture(input int mode);
        for (int i = 0; i < NCAP; i++) begin
            tr_tx[i]   = bus.tx;
            tr_busy[i] = bus.busy;
            tr_done[i] = bus.done;
            tr_rd[i]   = bus.ram_rd_en;
            tr_addr[i] = bus.ram_addr;
            case (mode)
                1: bus.start = (i == 50 || i == 300);
                2: bus.start = 1'b1;
                default: bus.start = 1'b0;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic analyze(input string tag, input int mode);
        logic [7:0] exp_b[$];
        logic [7:0] got_b[$];
        bit         exp_w[$];
        logic [7:0] v;
        int bad, i, framing, rd_n, done_n, done_at, last;
        exp_b.push_back(8'hA5);
        for (int k = 0; k < 16; k++) exp_b.push_back(ram[k]);
        for (int k = 0; k < NB; k++) begin
            if (k > 0) begin
                exp_w.push_back(1'b1);
                exp_w.push_back(1'b1);
            end
            for (int c = 0; c < CPB; c++) exp_w.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < CPB; c++) exp_w.push_back(exp_b[k][b]);
            for (int c = 0; c < CPB; c++) exp_w.push_back(1'b1);
        end
        exp_w.push_back(1'b1);
        bad = -1;
        for (int j = 0; j < exp_w.size(); j++)
            if (tr_tx[j] !== exp_w[j] && bad < 0) bad = j;
        check({tag, "_tx_wave"}, 32'(bad), 32'hFFFFFFFF);
        i = 0;
        framing = 0;
        while (i < DONE_IDX) begin
            if (!tr_tx[i]) begin
                for (int b = 0; b < 8; b++)
                    v[b] = tr_tx[i + CPB / 2 + CPB * (b + 1)];
                if (!tr_tx[i + CPB / 2 + 9 * CPB]) framing++;
                got_b.push_back(v);
                i += BYTE_CYC;
            end else begin
                i++;
            end
        end
        check({tag, "_nbytes"}, 32'(got_b.size()), 32'(NB));
        check({tag, "_framing"}, 32'(framing), 32'd0);
        bad = -1;
        for (int k = 0; k < NB && k < got_b.size(); k++)
            if (got_b[k] !== exp_b[k] && bad < 0) bad = k;
        check({tag, "_bytes"}, 32'(bad), 32'hFFFFFFFF);
        if (got_b.size() > 0) check({tag, "_hdr"}, 32'(got_b[0]), 32'hA5);
        rd_n = 0;
        bad = -1;
        for (int j = 0; j < NCAP - 1; j++) begin
            if (tr_rd[j]) begin
                if (rd_n >= 16 || j != (rd_n + 1) * SLOT - 2 ||
                    tr_addr[j] !== 4'(rd_n) || tr_addr[j + 1] !== 4'(rd_n))
                    if (bad < 0) bad = j;
                rd_n++;
            end
        end
        check({tag, "_rd_count"}, 32'(rd_n), 32'd16);
        check({tag, "_rd_seq"}, 32'(bad), 32'hFFFFFFFF);
        last = (mode == 2) ? DONE_IDX : NCAP - 1;
        bad = -1;
        for (int j = 0; j <= last; j++)
            if (tr_busy[j] !== (j < DONE_IDX) && bad < 0) bad = j;
        check({tag, "_busy"}, 32'(bad), 32'hFFFFFFFF);
        done_n = 0;
        done_at = -1;
        for (int j = 0; j < NCAP; j++)
            if (tr_done[j]) begin
                done_n++;
                if (done_at < 0) done_at = j;
            end
        check({tag, "_done_n"}, 32'(done_n), 32'd1);
        check({tag, "_done_at"}, 32'(done_at), 32'(DONE_IDX));
        check({tag, "_gap"},
              {29'd0, tr_tx[BYTE_CYC], tr_tx[BYTE_CYC + 1], tr_tx[SLOT]},
              32'b110);
        if (mode == 2) begin
            check({tag, "_b2b_tx"}, 32'(tr_tx[DONE_IDX + 1]), 32'd0);
            check({tag, "_b2b_busy"}, 32'(tr_busy[DONE_IDX + 1]), 32'd1);
        end
    endtask

    initial begin
        int bad;
        logic [9:0] frame;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'(16 + i);
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd", 32'(bus.ram_rd_en), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0)
                bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        start_dump();
        check("a_first_tx", 32'(bus.tx), 32'd0);
        check("a_first_busy", 32'(bus.busy), 32'd1);
        capture(0);
        analyze("dumpA", 0);

        fill_random();
        ram[0] = 8'h81;
        start_dump();
        capture(1);
        analyze("dumpB", 1);
        for (int b = 0; b < 10; b++) frame[b] = tr_tx[SLOT + CPB * b + 1];
        check("b_frame81", 32'(frame), 32'(10'b1100000010));

        fill_random();
        start_dump();
        capture(2);
        analyze("dumpC", 2);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill_random();
        ram[5][3] = 1'b0;
        start_dump();
        repeat (5 * SLOT + SLOT + 4 * CPB + 1) @(negedge clk);
        check("d_pre_tx", 32'(bus.tx), 32'd0);
        check("d_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("d_rst_tx", 32'(bus.tx), 32'd1);
        check("d_rst_busy", 32'(bus.busy), 32'd0);
        check("d_rst_done", 32'(bus.done), 32'd0);
        check("d_rst_rd", 32'(bus.ram_rd_en), 32'd0);
        check("d_rst_addr", 32'(bus.ram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill_random();
        start_dump();
        capture(0);
        analyze("dumpE", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
